// File: rtl/life_engine_pkg.sv
// Shared types and rule constants for the Game of Life engine.
// States, birth/survival neighbour counts and the neighbour-sum width.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVOLVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int BIRTH_COUNT   = 3;
  localparam int SURVIVE_COUNT = 2;
  localparam int NBR_W         = 4;

endpackage

// File: rtl/life_row_evolve.sv
// Combinational next-generation evaluator for one grid row, given the rows
// above and below; wrap selects toroidal column edges instead of dead ones.
module life_row_evolve
  import life_pkg::*;
#(
  parameter int COLS = 8
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  input  logic            wrap,
  output logic [COLS-1:0] nxt
);

  for (genvar c = 0; c < COLS; c++) begin : g_cell
    localparam int L = (c == 0) ? COLS - 1 : c - 1;
    localparam int R = (c == COLS - 1) ? 0 : c + 1;

    logic             w_useL;
    logic             w_useR;
    logic [2:0]       w_colL;
    logic [2:0]       w_colR;
    logic [NBR_W-1:0] w_sum;

    // Edge columns only see their wrapped neighbours in toroidal mode.
    if (c == 0) begin : g_leftEdge
      assign w_useL = wrap;
    end else begin : g_leftInner
      assign w_useL = 1'b1;
    end

    if (c == COLS - 1) begin : g_rightEdge
      assign w_useR = wrap;
    end else begin : g_rightInner
      assign w_useR = 1'b1;
    end

    assign w_colL = {above[L], cur[L], below[L]} & {3{w_useL}};
    assign w_colR = {above[R], cur[R], below[R]} & {3{w_useR}};

    assign w_sum = NBR_W'(w_colL[2]) + NBR_W'(w_colL[1]) + NBR_W'(w_colL[0])
                 + NBR_W'(w_colR[2]) + NBR_W'(w_colR[1]) + NBR_W'(w_colR[0])
                 + NBR_W'(above[c])  + NBR_W'(below[c]);

    assign nxt[c] = (w_sum == NBR_W'(BIRTH_COUNT)) ||
                    ((w_sum == NBR_W'(SURVIVE_COUNT)) && cur[c]);
  end

endmodule

// File: rtl/life_engine.sv
// Row-serial Game of Life engine: a ROWS x COLS register grid evolved one row
// per cycle through a 3-row window, with row load/read and generation status.
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [ROW_W-1:0] load_row,
  input  logic [COLS-1:0]  load_data,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic             wrap_mode,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             extinct
);

  state_t           r_state;
  state_t           w_nextState;
  logic [COLS-1:0]  r_grid [ROWS];
  logic [ROW_W-1:0] r_row;
  logic [COLS-1:0]  r_prevRow;
  logic [COLS-1:0]  r_row0Orig;
  logic             r_wrap;
  logic             r_changed;
  logic             r_anyAlive;
  logic             r_stable;
  logic             r_extinct;
  logic [GEN_W-1:0] r_genCount;

  logic             w_loadFire;
  logic             w_loadInRange;
  logic             w_stepFire;
  logic             w_lastRow;
  logic [ROW_W-1:0] w_rowNext;
  logic [COLS-1:0]  w_cur;
  logic [COLS-1:0]  w_below;
  logic [COLS-1:0]  w_nxt;
  logic             w_loadAlive;

  assign w_loadFire    = load_valid && load_ready;
  assign w_stepFire    = step_valid && step_ready;
  assign w_loadInRange = int'(load_row) < ROWS;
  assign w_lastRow     = (r_row == ROW_W'(ROWS - 1));
  assign w_rowNext     = w_lastRow ? '0 : r_row + 1'b1;
  assign w_cur         = r_grid[r_row];
  // Row 0 has already been overwritten by the time the last row is evaluated.
  assign w_below       = w_lastRow ? (r_wrap ? r_row0Orig : '0) : r_grid[w_rowNext];

  life_row_evolve #(
    .COLS (COLS)
  ) u_rowEvolve (
    .above (r_prevRow),
    .cur   (w_cur),
    .below (w_below),
    .wrap  (r_wrap),
    .nxt   (w_nxt)
  );

  always_comb begin
    w_nextState = r_state;
    load_ready  = 1'b0;
    step_ready  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        step_ready = !load_valid;
        busy       = 1'b0;
        if (step_valid && !load_valid) w_nextState = EVOLVE;
      end
      EVOLVE: begin
        if (w_lastRow) w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Liveness of the grid as it will look once the pending load lands.
  always_comb begin
    w_loadAlive = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (ROW_W'(i) == load_row) w_loadAlive = w_loadAlive | (|load_data);
      else                       w_loadAlive = w_loadAlive | (|r_grid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) r_grid[i] <= '0;
    end else if (w_loadFire && w_loadInRange) begin
      r_grid[load_row] <= load_data;
    end else if (r_state == EVOLVE) begin
      r_grid[r_row] <= w_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row      <= '0;
      r_prevRow  <= '0;
      r_row0Orig <= '0;
      r_wrap     <= 1'b0;
      r_changed  <= 1'b0;
      r_anyAlive <= 1'b0;
      r_stable   <= 1'b0;
      r_extinct  <= 1'b1;
      r_genCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_loadFire) begin
            r_stable  <= 1'b0;
            r_extinct <= !w_loadAlive;
          end else if (w_stepFire) begin
            r_wrap     <= wrap_mode;
            r_row      <= '0;
            r_prevRow  <= wrap_mode ? r_grid[ROWS-1] : '0;
            r_row0Orig <= r_grid[0];
            r_changed  <= 1'b0;
            r_anyAlive <= 1'b0;
          end
        end
        EVOLVE: begin
          r_prevRow  <= w_cur;
          r_changed  <= r_changed | (w_nxt != w_cur);
          r_anyAlive <= r_anyAlive | (|w_nxt);
          if (!w_lastRow) r_row <= r_row + 1'b1;
        end
        DONE: begin
          if (r_genCount != '1) r_genCount <= r_genCount + 1'b1;
          r_stable  <= !r_changed;
          r_extinct <= !r_anyAlive;
        end
        default: begin
          r_row <= '0;
        end
      endcase
    end
  end

  assign rd_data   = (int'(rd_row) < ROWS) ? r_grid[rd_row] : '0;
  assign gen_count = r_genCount;
  assign stable    = r_stable;
  assign extinct   = r_extinct;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine against a cell-by-cell Game of Life model.
module tb_life_engine;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 16;
  localparam int ROW_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [ROW_W-1:0] load_row = '0;
  logic [COLS-1:0]  load_data = '0;
  logic             step_valid = 1'b0;
  logic             step_ready;
  logic             wrap_mode = 1'b0;
  logic [ROW_W-1:0] rd_row = '0;
  logic [COLS-1:0]  rd_data;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic             stable;
  logic             extinct;

  int checks = 0;
  int errors = 0;

  bit       mGrid [ROWS][COLS];
  int       mGen;
  bit       mStable;
  bit       mExtinct;

  life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_row   (load_row),
    .load_data  (load_data),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .wrap_mode  (wrap_mode),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .gen_count  (gen_count),
    .stable     (stable),
    .extinct    (extinct)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [COLS-1:0] modelRow(int r);
    logic [COLS-1:0] v;
    for (int c = 0; c < COLS; c++) v[c] = mGrid[r][c];
    return v;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mGrid[r][c] = 1'b0;
    mGen = 0; mStable = 1'b0; mExtinct = 1'b1;
  endtask

  task automatic modelLoad(int row, logic [COLS-1:0] data);
    bit any;
    if (row < ROWS)
      for (int c = 0; c < COLS; c++) mGrid[row][c] = data[c];
    any = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) any = any | mGrid[r][c];
    mStable = 1'b0; mExtinct = !any;
  endtask

  task automatic modelStep(bit wrap);
    bit nx [ROWS][COLS];
    bit chg, any;
    int n, rr, cc;
    chg = 1'b0; any = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr; cc = c + dc;
            if (wrap) begin
              rr = (rr + ROWS) % ROWS; cc = (cc + COLS) % COLS;
            end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
              continue;
            end
            n += int'(mGrid[rr][cc]);
          end
        end
        nx[r][c] = (n == 3) || (n == 2 && mGrid[r][c]);
        if (nx[r][c] != mGrid[r][c]) chg = 1'b1;
        if (nx[r][c]) any = 1'b1;
      end
    end
    mGrid = nx;
    if (mGen < (1 << GEN_W) - 1) mGen++;
    mStable = !chg; mExtinct = !any;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic applyReset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    modelReset();
  endtask

  task automatic doLoad(int row, logic [COLS-1:0] data);
    @(negedge clk);
    load_valid = 1'b1; load_row = ROW_W'(row); load_data = data;
    @(negedge clk);
    load_valid = 1'b0;
    modelLoad(row, data);
  endtask

  task automatic readRow(int r, output logic [COLS-1:0] v);
    rd_row = ROW_W'(r);
    #1;
    v = rd_data;
  endtask

  // Issues one step, returns edges-to-done (-1 if never) and done pulse width.
  task automatic runStep(bit wrap, output int lat, output int width);
    lat = -1; width = 0;
    @(negedge clk);
    wrap_mode = wrap; step_valid = 1'b1;
    for (int k = 0; k <= ROWS + 3; k++) begin
      @(negedge clk);
      if (k == 0) step_valid = 1'b0;
      if (done === 1'b1) begin
        if (lat < 0) lat = k;
        width++;
      end
    end
    modelStep(wrap);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [COLS-1:0] v;
    doLoad(1, 8'hA5);
    applyReset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (gen_count !== '0) begin errors++; $display("FAIL reset_gen got %0d want 0", gen_count); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL reset_stable got %b want 0", stable); end
    checks++; if (extinct !== 1'b1) begin errors++; $display("FAIL reset_extinct got %b want 1", extinct); end
    checks++; if (load_ready !== 1'b1 || step_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got load=%b step=%b want 1/1", load_ready, step_ready);
    end
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      checks++; if (v !== '0) begin errors++; $display("FAIL reset_row%0d got %b want 0", r, v); end
    end
  endtask

  task automatic test_blinker();
    logic [COLS-1:0] v;
    int lat, wid;
    applyReset();
    doLoad(3, 8'b0001_1100);
    checks++; if (extinct !== 1'b0) begin errors++; $display("FAIL blinker_load_extinct got %b want 0", extinct); end
    runStep(1'b0, lat, wid);
    checks++; if (lat !== ROWS) begin errors++; $display("FAIL blinker_latency got %0d want %0d", lat, ROWS); end
    checks++; if (wid !== 1) begin errors++; $display("FAIL blinker_done_width got %0d want 1", wid); end
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      checks++; if (v !== modelRow(r)) begin errors++; $display("FAIL blinker_g1_row%0d got %b want %b", r, v, modelRow(r)); end
    end
    readRow(2, v);
    checks++; if (v !== 8'b0000_1000) begin errors++; $display("FAIL blinker_row2 got %b want 00001000", v); end
    runStep(1'b0, lat, wid);
    readRow(3, v);
    checks++; if (v !== 8'b0001_1100) begin errors++; $display("FAIL blinker_row3_restored got %b want 00011100", v); end
    checks++; if (gen_count !== 16'd2) begin errors++; $display("FAIL blinker_gen got %0d want 2", gen_count); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL blinker_stable got %b want 0", stable); end
  endtask

  task automatic test_block();
    logic [COLS-1:0] v;
    int lat, wid;
    applyReset();
    doLoad(3, 8'b0001_1000);
    doLoad(4, 8'b0001_1000);
    runStep(1'b0, lat, wid);
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      checks++; if (v !== modelRow(r)) begin errors++; $display("FAIL block_row%0d got %b want %b", r, v, modelRow(r)); end
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL block_stable got %b want 1", stable); end
    checks++; if (extinct !== 1'b0) begin errors++; $display("FAIL block_extinct got %b want 0", extinct); end
  endtask

  task automatic test_single();
    logic [COLS-1:0] v;
    int lat, wid;
    applyReset();
    doLoad(4, 8'b0001_0000);
    runStep(1'b1, lat, wid);
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      checks++; if (v !== '0) begin errors++; $display("FAIL single_row%0d got %b want 0", r, v); end
    end
    checks++; if (extinct !== 1'b1) begin errors++; $display("FAIL single_extinct got %b want 1", extinct); end
    checks++; if (wid !== 1) begin errors++; $display("FAIL single_done_width got %0d want 1", wid); end
  endtask

  task automatic test_corner_wrap();
    logic [COLS-1:0] v;
    int lat, wid;
    applyReset();
    doLoad(0, 8'b1000_0001);
    doLoad(7, 8'b0000_0001);
    runStep(1'b0, lat, wid);
    readRow(7, v);
    checks++; if (v[7] !== 1'b0) begin errors++; $display("FAIL corner_dead_77 got %b want 0", v[7]); end
    checks++; if (extinct !== 1'b1) begin errors++; $display("FAIL corner_dead_extinct got %b want 1", extinct); end
    doLoad(0, 8'b1000_0001);
    doLoad(7, 8'b0000_0001);
    runStep(1'b1, lat, wid);
    readRow(0, v);
    checks++; if (v !== 8'b1000_0001) begin errors++; $display("FAIL corner_wrap_row0 got %b want 10000001", v); end
    readRow(7, v);
    checks++; if (v !== 8'b1000_0001) begin errors++; $display("FAIL corner_wrap_row7 got %b want 10000001", v); end
    for (int r = 1; r < ROWS - 1; r++) begin
      readRow(r, v);
      checks++; if (v !== modelRow(r)) begin errors++; $display("FAIL corner_wrap_row%0d got %b want %b", r, v, modelRow(r)); end
    end
    checks++; if (stable !== 1'b0 || extinct !== 1'b0) begin
      errors++; $display("FAIL corner_wrap_status got stable=%b extinct=%b want 0/0", stable, extinct);
    end
  endtask

  task automatic test_glider();
    logic [COLS-1:0] init [ROWS];
    logic [COLS-1:0] v;
    int lat, wid;
    bit same;
    for (int r = 0; r < ROWS; r++) init[r] = '0;
    init[0] = 8'b0000_0010; init[1] = 8'b0000_0100; init[2] = 8'b0000_0111;
    applyReset();
    for (int r = 0; r < 3; r++) doLoad(r, init[r]);
    for (int s = 0; s < 32; s++) runStep(1'b1, lat, wid);
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      checks++; if (v !== init[r]) begin errors++; $display("FAIL glider_wrap_row%0d got %b want %b", r, v, init[r]); end
    end
    checks++; if (gen_count !== 16'd32) begin errors++; $display("FAIL glider_gen got %0d want 32", gen_count); end
    applyReset();
    for (int r = 0; r < 3; r++) doLoad(r, init[r]);
    for (int s = 0; s < 32; s++) runStep(1'b0, lat, wid);
    same = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      if (v !== init[r]) same = 1'b0;
      checks++; if (v !== modelRow(r)) begin errors++; $display("FAIL glider_dead_row%0d got %b want %b", r, v, modelRow(r)); end
    end
    checks++; if (same) begin errors++; $display("FAIL glider_dead_returned got initial pattern want different"); end
  endtask

  task automatic test_random();
    logic [COLS-1:0] v;
    int lat, wid;
    bit wrap;
    for (int t = 0; t < 4; t++) begin
      applyReset();
      for (int r = 0; r < ROWS; r++) doLoad(r, COLS'($urandom_range(0, 255)));
      for (int s = 0; s < 5; s++) begin
        wrap = 1'($urandom_range(0, 1));
        runStep(wrap, lat, wid);
        checks++; if (lat !== ROWS || wid !== 1) begin
          errors++; $display("FAIL rand_timing got lat=%0d width=%0d want %0d/1", lat, wid, ROWS);
        end
        for (int r = 0; r < ROWS; r++) begin
          readRow(r, v);
          checks++; if (v !== modelRow(r)) begin errors++; $display("FAIL rand_t%0d_s%0d_row%0d got %b want %b", t, s, r, v, modelRow(r)); end
        end
        checks++; if (gen_count !== GEN_W'(mGen) || stable !== mStable || extinct !== mExtinct) begin
          errors++; $display("FAIL rand_status got gen=%0d st=%b ex=%b want gen=%0d st=%b ex=%b",
                            gen_count, stable, extinct, mGen, mStable, mExtinct);
        end
      end
    end
  endtask

  task automatic test_reset_mid_evolve();
    logic [COLS-1:0] v;
    int lat, wid, doneSeen;
    applyReset();
    for (int r = 0; r < ROWS; r++) doLoad(r, COLS'($urandom_range(1, 255)));
    runStep(1'b1, lat, wid);
    @(negedge clk);
    wrap_mode = 1'b1; step_valid = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) step_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      checks++; if (v !== '0) begin errors++; $display("FAIL midreset_row%0d got %b want 0", r, v); end
    end
    checks++; if (gen_count !== '0) begin errors++; $display("FAIL midreset_gen got %0d want 0", gen_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    doneSeen = 0;
    for (int k = 0; k < ROWS + 4; k++) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    checks++; if (doneSeen !== 0) begin errors++; $display("FAIL midreset_done got %0d pulses want 0", doneSeen); end
  endtask

  task automatic test_back_to_back();
    logic [COLS-1:0] v;
    logic [COLS-1:0] data;
    int waited;
    applyReset();
    doLoad(3, 8'b0011_1000);
    data = 8'b0000_1110;
    @(negedge clk);
    load_valid = 1'b1; load_row = 3'd2; load_data = data;
    step_valid = 1'b1; wrap_mode = 1'b1;
    #1;
    checks++; if (step_ready !== 1'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL collide_ready got step=%b load=%b want 0/1", step_ready, load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
    modelLoad(2, data);
    #1;
    checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL collide_step_pending got %b want 1", step_ready); end
    @(negedge clk);
    step_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL collide_step_accept got busy=%b want 1", busy); end
    load_valid = 1'b1; load_row = 3'd0; load_data = 8'hFF;
    #1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL busy_load_ready got %b want 0", load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 4 * ROWS) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collide_timeout got busy=%b want 0", busy); end
    modelStep(1'b1);
    for (int r = 0; r < ROWS; r++) begin
      readRow(r, v);
      checks++; if (v !== modelRow(r)) begin errors++; $display("FAIL collide_row%0d got %b want %b", r, v, modelRow(r)); end
    end
    checks++; if (gen_count !== 16'd1) begin errors++; $display("FAIL collide_gen got %0d want 1", gen_count); end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_blinker();
    test_block();
    test_single();
    test_corner_wrap();
    test_glider();
    test_random();
    test_reset_mid_evolve();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
